// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the junction traffic-light controller:
//   - state_t      controller states
//   - RED/YEL/GRN/OFF one-hot {red,yellow,green} light encodings
//   - LONG_T/SHORT_T/YELLOW_T durations loaded into the countdown timer
//   - WDOG_CYCLES  cycles a timed state may wait for expiry before faulting
//   - helper functions mapping a state to its duration and light pattern
package traffic_pkg;

  typedef enum logic [2:0] {
    INIT,
    HG,
    HY,
    FG,
    FY,
    FAULT
  } state_t;

  localparam int DUR_W = 4;

  localparam logic [DUR_W-1:0] LONG_T   = 4'd5;
  localparam logic [DUR_W-1:0] SHORT_T  = 4'd3;
  localparam logic [DUR_W-1:0] YELLOW_T = 4'd1;
  localparam logic [7:0]       WDOG_CYCLES = 8'd64;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  // States that run the timer and so get a start pulse on entry
  function automatic logic isTimed(input state_t s);
    return (s == HG) || (s == HY) || (s == FG) || (s == FY);
  endfunction

  function automatic logic [DUR_W-1:0] stateDuration(input state_t s);
    case (s)
      HG:      return LONG_T;
      HY, FY:  return YELLOW_T;
      FG:      return SHORT_T;
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] hwyLights(input state_t s);
    case (s)
      HG:      return GRN;
      HY:      return YEL;
      default: return RED;
    endcase
  endfunction

  function automatic logic [2:0] farmLights(input state_t s);
    case (s)
      FG:      return GRN;
      FY:      return YEL;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if
// Handshake between the light controller (initiator) and the countdown timer.
//   start_timer : one-cycle load pulse, controller -> timer
//   value       : duration to load, valid while start_timer=1
//   expired     : timer has run out, timer -> controller
interface traffic_light_ctrl_if;

  logic                          start_timer;
  logic [traffic_pkg::DUR_W-1:0] value;
  logic                          expired;

  modport master (output start_timer, output value, input expired);
  modport slave  (input start_timer, input value, output expired);

endinterface

// File: rtl/timer.sv
// timer
// Shared countdown timer. A start pulse loads value; expired rises value+1
// cycles after the start cycle and stays high until the next start pulse.
//   clk, g_reset : clock, asynchronous active-low reset
//   value        : duration to load
//   start_timer  : load pulse
//   expired      : level, timer has run out
module timer (
  input  logic       clk,
  input  logic       g_reset,
  input  logic [3:0] value,
  input  logic       start_timer,
  output logic       expired
);

  logic [3:0] r_count;
  logic       r_running;
  logic       r_expired;

  // Countdown; expired is held as a level so late readers still see it
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      r_count   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else if (start_timer) begin
      r_count   <= value;
      r_running <= 1'b1;
      r_expired <= 1'b0;
    end else if (r_running) begin
      if (r_count <= 4'd1) begin
        r_count   <= '0;
        r_running <= 1'b0;
        r_expired <= 1'b1;
      end else begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/wdog_counter.sv
// wdog_counter
// 8-bit watchdog: cleared on request, counts while enabled, and flags the
// cycle on which it is about to reach LIMIT.
//   clk, g_reset : clock, asynchronous active-low reset
//   i_clear      : restart the count from zero
//   i_enable     : count this cycle
//   o_terminal   : count reaches LIMIT on the coming edge
module wdog_counter #(
  parameter logic [7:0] LIMIT = 8'd64
) (
  input  logic clk,
  input  logic g_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [7:0] r_count;

  // Clear wins over counting so a fresh start always begins at zero
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Looks one edge ahead so the fault state is entered exactly as the count
  // reaches LIMIT; deliberately independent of i_clear to avoid a comb loop
  assign o_terminal = i_enable && (r_count == LIMIT - 8'd1);

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Highway / farm-road light sequencer driving the shared countdown timer.
//   clk, g_reset : clock, asynchronous active-low reset
//   tif          : timer handshake (start_timer, value out; expired in)
//   car          : farm-road vehicle present
//   hwy_light    : one-hot {red,yellow,green} for the highway
//   farm_light   : one-hot {red,yellow,green} for the farm road
//   cycle_count  : completed FY->HG cycles, wraps at 256
//   fault        : watchdog tripped, sticky until reset
module traffic_light_ctrl
  import traffic_pkg::*;
(
  input  logic                        clk,
  input  logic                        g_reset,
  traffic_light_ctrl_if.master        tif,
  input  logic                        car,
  output logic [2:0]                  hwy_light,
  output logic [2:0]                  farm_light,
  output logic [7:0]                  cycle_count,
  output logic                        fault
);

  state_t           r_state;
  logic             r_startTimer;
  logic [DUR_W-1:0] r_value;
  logic [2:0]       r_hwyLight;
  logic [2:0]       r_farmLight;
  logic [7:0]       r_cycleCount;
  logic             r_fault;
  logic             r_done;
  logic [2:0]       r_flash;

  state_t           w_nextState;
  logic             w_nextStart;
  logic [DUR_W-1:0] w_nextValue;
  logic [2:0]       w_nextHwy;
  logic [2:0]       w_nextFarm;
  logic [7:0]       w_nextCount;
  logic             w_nextFault;
  logic             w_nextDone;

  logic w_expired;
  logic w_wdogEnable;
  logic w_wdogTrip;
  logic w_flashOff;

  // An expiry seen during our own start cycle belongs to the previous run
  assign w_expired    = tif.expired && !r_startTimer;
  assign w_wdogEnable = isTimed(r_state) && !r_done;
  // Lights for the next fault cycle go dark when r_flash+1 has bit 2 set
  assign w_flashOff   = (r_flash >= 3'd3) && (r_flash != 3'd7);

  wdog_counter #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk        (clk),
    .g_reset    (g_reset),
    .i_clear    (w_nextStart),
    .i_enable   (w_wdogEnable),
    .o_terminal (w_wdogTrip)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    w_nextState = r_state;
    w_nextStart = 1'b0;
    w_nextValue = r_value;
    w_nextHwy   = r_hwyLight;
    w_nextFarm  = r_farmLight;
    w_nextCount = r_cycleCount;
    w_nextFault = r_fault;
    w_nextDone  = r_done;

    case (r_state)
      INIT: w_nextState = HG;
      HG: begin
        if (w_expired) w_nextDone = 1'b1;
        if ((r_done || w_expired) && car) w_nextState = HY;
      end
      HY:    if (w_expired) w_nextState = FG;
      FG:    if (w_expired || !car) w_nextState = FY;
      FY:    if (w_expired) w_nextState = HG;
      FAULT: w_nextState = FAULT;
      default: w_nextState = INIT;
    endcase

    if (w_wdogTrip) w_nextState = FAULT;

    if (r_state == FY && w_nextState == HG) w_nextCount = r_cycleCount + 8'd1;

    // Entering a state: set its lights, and for timed states load the timer
    if (w_nextState != r_state) begin
      w_nextHwy  = hwyLights(w_nextState);
      w_nextFarm = farmLights(w_nextState);
      if (isTimed(w_nextState)) begin
        w_nextStart = 1'b1;
        w_nextValue = stateDuration(w_nextState);
        w_nextDone  = 1'b0;
      end
    end

    // Fault: first cycle yellow, then 4 yellow / 4 dark from the flash counter
    if (w_nextState == FAULT) begin
      w_nextFault = 1'b1;
      if (r_state != FAULT) begin
        w_nextHwy  = YEL;
        w_nextFarm = YEL;
      end else begin
        w_nextHwy  = w_flashOff ? OFF : YEL;
        w_nextFarm = w_flashOff ? OFF : YEL;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      r_state      <= INIT;
      r_startTimer <= 1'b0;
      r_value      <= '0;
      r_hwyLight   <= RED;
      r_farmLight  <= RED;
      r_cycleCount <= '0;
      r_fault      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_startTimer <= w_nextStart;
      r_value      <= w_nextValue;
      r_hwyLight   <= w_nextHwy;
      r_farmLight  <= w_nextFarm;
      r_cycleCount <= w_nextCount;
      r_fault      <= w_nextFault;
      r_done       <= w_nextDone;
    end
  end

  // Flash phase counter, held at zero outside FAULT so the pattern starts
  // with a full yellow phase
  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      r_flash <= '0;
    end else if (r_state != FAULT) begin
      r_flash <= '0;
    end else begin
      r_flash <= r_flash + 3'd1;
    end
  end

  assign tif.start_timer = r_startTimer;
  assign tif.value       = r_value;
  assign hwy_light       = r_hwyLight;
  assign farm_light      = r_farmLight;
  assign cycle_count     = r_cycleCount;
  assign fault           = r_fault;

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

- Two-road traffic-light controller (highway / farm road) that drives the shared countdown `timer` block as its initiator.
- Loads `value`, pulses `start_timer`, waits for `expired`, and sequences the lights on the farm-road car sensor.
- A watchdog catches a timer that never expires and parks the junction in a flashing-yellow fault state.
- Sits beside `timer` at junction top level; `timer` is unchanged.

## Interface
- `LONG_T`, 4'd5, highway-green minimum duration loaded into timer
- `SHORT_T`, 4'd3, farm-green maximum duration
- `YELLOW_T`, 4'd1, yellow duration (both roads)
- `WDOG_CYCLES`, 8'd64, cycles allowed between start pulse and `expired` before fault
- `clk` in 1 — single clock, rising edge
- `g_reset` in 1 — asynchronous, active-low reset
- `car` in 1 — farm-road vehicle present (synchronous to `clk`)
- `expired` in 1 — from timer
- `start_timer` out 1 — one-cycle load pulse to timer
- `value` out 4 — duration for timer, valid while `start_timer`=1
- `hwy_light` out 3 — one-hot {red,yellow,green}
- `farm_light` out 3 — one-hot {red,yellow,green}
- `cycle_count` out 8 — completed FY→HG cycles, wraps 255→0
- `fault` out 1 — watchdog tripped, sticky until reset

## Operation
- States: INIT, HG, HY, FG, FY, FAULT. All outputs registered.
- Reset values: state INIT, `start_timer`=0, `value`=0, both lights red (3'b100), `cycle_count`=0, `fault`=0, watchdog 0, `done` flag 0.
- Entering any timed state: `start_timer`=1 and `value`=duration for exactly the first cycle in that state; watchdog cleared; `done`=0.
- INIT → HG unconditionally on first edge after reset release (value=LONG_T).
- HG (hwy green, farm red): `expired` sets `done`. Leave to HY (YELLOW_T) when `done|expired` and `car`=1; if expired with no car, stay in HG, no restart, watchdog stops.
- HY (hwy yellow, farm red): `expired` → FG (SHORT_T).
- FG (hwy red, farm green): `expired` or `car`=0 → FY (YELLOW_T); both in the same cycle → single transition.
- FY (hwy red, farm yellow): `expired` → HG (LONG_T); `cycle_count` increments on this transition.
- `expired` sampled in the start cycle itself is ignored (stale from previous run).
- Watchdog: 8-bit, counts every cycle in a timed state while `done`=0 after the start cycle. Reaching WDOG_CYCLES → FAULT.
- FAULT: `fault`=1, `start_timer`=0, both lights yellow for 4 cycles then all-off for 4 (free 3-bit counter, bit 2), forever until `g_reset`.
- `car` changes in HY/FY are ignored.

## Timing
- Start pulse latency: 1 cycle after the transition condition is sampled (registered).
- Expiry → light change: 1 clock edge.
- Async reset mid-operation: outputs go to reset values immediately, independent of `clk`. Timer's own reset shares `g_reset`.
- `value` holds its last driven duration after the start cycle (do not return to 0).

## Structure
- `traffic_pkg`: state enum, light encodings (RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000), default durations.
- One sub-module natural: `wdog_counter` (clear, enable, terminal-count compare, 8-bit).
- Bench instantiates real `timer` with `clk`, `g_reset`, `value`, `start_timer`, `expired` connected point-to-point.

## Test plan
- Reset 1 cycle low, release with `car`=0 → start pulse with value=5 on first edge, HG, `expired` after timer run, controller stays HG, `start_timer` stays 0, `fault`=0 after 200 cycles.
- `car`=1 held → full HG→HY(value=1)→FG(value=3)→FY(value=1)→HG(value=5); `cycle_count`=1; each light one-hot at every cycle.
- In FG drop `car` 1 cycle after start → FY next edge, no wait for expiry; `car` and `expired` coincident → exactly one FY start pulse.
- Tie `expired`=0 (timer disconnected) with `car`=1 → FAULT exactly 64 cycles after the HG start pulse; yellows toggle 4 on / 4 off; `fault` stays 1 until reset.
- Assert `g_reset` mid-FG → lights red/red, `start_timer`=0, `cycle_count`=0 asynchronously; on release restart from INIT.
- Run 256 full cycles → `cycle_count` wraps to 0.
